// File: rtl/chimp_pkg.sv
// Shared types and constants for the chimp-test board loader: FSM states, grid
// geometry, LFSR shape and the press-number bus width.
package chimp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_PICK  = 3'd2,
    ST_PLACE = 3'd3,
    ST_DRAW  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam int C_GRID_W    = 8;
  localparam int C_GRID_H    = 4;
  localparam int C_CELLS     = C_GRID_W * C_GRID_H;
  localparam int C_MAX_LEVEL = 31;
  localparam int CELL_W      = 5;
  localparam int PROBE_W     = 6;

  localparam int              LFSR_W      = 16;
  // Taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS   = 16'hB400;
  localparam logic [LFSR_W-1:0] C_LFSR_SEED = 16'hACE1;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/chimp_lfsr16.sv
// 16-bit Fibonacci LFSR that advances one step per cycle while iStep is high.
module chimp_lfsr16
  import chimp_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = C_LFSR_SEED
) (
  input  logic              clk,
  input  logic              iResetn,
  input  logic              iStep,
  output logic [LFSR_W-1:0] oValue
);

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      oValue <= SEED;
    end else if (iStep) begin
      oValue <= lfsr_next(oValue);
    end
  end

endmodule

// File: rtl/chimp_board_loader.sv
// Builds a chimp-test board: clears the cell->number table, places L tiles on
// random free cells and hands each to the renderer. Optional CHIMP_LFSR_FREERUN_EN.
module chimp_board_loader
  import chimp_pkg::*;
#(
  parameter int                GRID_W    = C_GRID_W,
  parameter int                GRID_H    = C_GRID_H,
  parameter int                MAX_LEVEL = C_MAX_LEVEL,
  parameter logic [LFSR_W-1:0] LFSR_SEED = C_LFSR_SEED
) (
  input  logic               clk,
  input  logic               iResetn,
  input  logic               iStart,
  input  logic [CELL_W-1:0]  iLevel,
  input  logic               iClear,
  output logic               oBusy,
  output logic               oDone,
  output logic               oDrawReq,
  input  logic               iDrawAck,
  output logic [CELL_W-1:0]  oDrawCell,
  output logic [CELL_W-1:0]  oDrawNum,
  input  logic [CELL_W-1:0]  iProbeCell,
  output logic [PROBE_W-1:0] oProbeNum,
  output state_t             dbg_state
);

  // Cell indices wrap naturally at CELL_W bits, so CELLS must be 2**CELL_W.
  localparam int CELLS = GRID_W * GRID_H;

  state_t            state, state_nxt;
  logic [CELL_W-1:0] tbl [CELLS];
  logic [CELL_W-1:0] level, level_clamped, k, cand, clr_idx;
  logic              build;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_step;
  logic              latch_start, latch_clear, clr_en, pick_entry, probe_adv;
  logic              place_en, ack_fire, k_inc;

  always_comb begin
    level_clamped = iLevel;
    if (iLevel == '0) begin
      level_clamped = CELL_W'(1);
    end else if (int'(iLevel) > MAX_LEVEL) begin
      level_clamped = CELL_W'(MAX_LEVEL);
    end
  end

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Draw handshake: oDrawReq/oDrawCell/oDrawNum stay stable until a cycle in
  // which oDrawReq and iDrawAck are both high; that cycle transfers the tile.
  always_comb begin
    state_nxt   = state;
    latch_start = 1'b0;
    latch_clear = 1'b0;
    clr_en      = 1'b0;
    pick_entry  = 1'b0;
    probe_adv   = 1'b0;
    place_en    = 1'b0;
    ack_fire    = 1'b0;
    k_inc       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (iClear) begin
          latch_clear = 1'b1;
          state_nxt   = ST_CLEAR;
        end else if (iStart) begin
          latch_start = 1'b1;
          state_nxt   = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clr_en = 1'b1;
        if (clr_idx == CELL_W'(CELLS - 1)) begin
          if (build) begin
            pick_entry = 1'b1;
            state_nxt  = ST_PICK;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_PICK: begin
        if (tbl[cand] == '0) begin
          state_nxt = ST_PLACE;
        end else begin
          probe_adv = 1'b1;
        end
      end
      ST_PLACE: begin
        place_en  = 1'b1;
        state_nxt = ST_DRAW;
      end
      ST_DRAW: begin
        if (iDrawAck) begin
          ack_fire = 1'b1;
          if (k == level) begin
            state_nxt = ST_DONE;
          end else begin
            k_inc      = 1'b1;
            pick_entry = 1'b1;
            state_nxt  = ST_PICK;
          end
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      level     <= '0;
      k         <= '0;
      cand      <= '0;
      clr_idx   <= '0;
      build     <= 1'b0;
      oDrawReq  <= 1'b0;
      oDrawCell <= '0;
      oDrawNum  <= '0;
    end else begin
      if (latch_clear) begin
        build   <= 1'b0;
        clr_idx <= '0;
      end
      if (latch_start) begin
        build   <= 1'b1;
        clr_idx <= '0;
        level   <= level_clamped;
        k       <= CELL_W'(1);
      end
      if (clr_en)     clr_idx <= clr_idx + CELL_W'(1);
      // The candidate takes the LFSR value present on entry; the LFSR steps in the same cycle.
      if (pick_entry) cand <= lfsr[CELL_W-1:0];
      if (probe_adv)  cand <= cand + CELL_W'(1);
      if (place_en) begin
        oDrawReq  <= 1'b1;
        oDrawCell <= cand;
        oDrawNum  <= k;
      end
      if (ack_fire) oDrawReq <= 1'b0;
      if (k_inc)    k <= k + CELL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge iResetn) begin
    if (!iResetn) begin
      for (int i = 0; i < CELLS; i++) tbl[i] <= '0;
    end else if (clr_en) begin
      tbl[clr_idx] <= '0;
    end else if (place_en) begin
      tbl[cand] <= k;
    end
  end

`ifdef CHIMP_LFSR_FREERUN_EN
  // Idle stepping makes the layout depend on when the player starts the round.
  assign lfsr_step = pick_entry | (state == ST_IDLE);
`else
  assign lfsr_step = pick_entry;
`endif

  chimp_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .iResetn (iResetn),
    .iStep   (lfsr_step),
    .oValue  (lfsr)
  );

  assign oBusy     = (state != ST_IDLE);
  assign oDone     = (state == ST_DONE);
  assign oProbeNum = PROBE_W'(tbl[iProbeCell]);
  assign dbg_state = state;

endmodule

// File: tb/tb_chimp_board_loader.sv
// Bench for chimp_board_loader: table of build/clear operations checked against
// a reference placement model, plus a mid-build reset sequence.
module tb_chimp_board_loader;
  import chimp_pkg::*;

  logic       clk = 1'b0;
  logic       iResetn, iStart, iClear, iDrawAck;
  logic [4:0] iLevel, iProbeCell;
  logic       oBusy, oDone, oDrawReq;
  logic [4:0] oDrawCell, oDrawNum;
  logic [5:0] oProbeNum;
  state_t     dbg_state;

  chimp_board_loader dut (
    .clk        (clk),
    .iResetn    (iResetn),
    .iStart     (iStart),
    .iLevel     (iLevel),
    .iClear     (iClear),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oDrawReq   (oDrawReq),
    .iDrawAck   (iDrawAck),
    .oDrawCell  (oDrawCell),
    .oDrawNum   (oDrawNum),
    .iProbeCell (iProbeCell),
    .oProbeNum  (oProbeNum),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: table contents, LFSR state and expected draw stream.
  logic [15:0] m_lfsr;
  logic [4:0]  m_tbl [32];
  logic [9:0]  exp_q [$];

  function automatic logic [15:0] m_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    for (int i = 0; i < 32; i++) m_tbl[i] = '0;
    exp_q.delete();
  endtask

  // op 0 = build, 1 = clear, 2 = clear and start together. Returns expected busy cycles before DONE.
  function automatic int model_op(input int op, input logic [4:0] lvl, input int dly);
    int n, busy, probes;
    logic [4:0] c;
    busy = 32;
    for (int i = 0; i < 32; i++) m_tbl[i] = '0;
    if (op == 0) begin
      n = (lvl == 0) ? 1 : int'(lvl);
      for (int k = 1; k <= n; k++) begin
        c = m_lfsr[4:0];
        m_lfsr = m_step(m_lfsr);
        probes = 0;
        while (m_tbl[c] != 0) begin
          c = c + 5'd1;
          probes++;
        end
        m_tbl[c] = 5'(k);
        exp_q.push_back({c, 5'(k)});
        busy += 1 + probes + 1 + dly + 1;
      end
    end
    return busy;
  endfunction

  // Renderer model: acknowledges after ack_delay waiting cycles and scores every requested tile.
  int ack_delay = 0;
  int wait_cnt  = 0;
  int hs_count  = 0;

  initial begin
    iDrawAck = 1'b0;
    forever begin
      @(negedge clk);
      if (!iResetn) begin
        wait_cnt = 0;
      end else if (oDrawReq) begin
        if (exp_q.size() == 0) chk("req_expected", exp_q.size(), 1);
        else chk("draw_tile", {oDrawCell, oDrawNum}, exp_q[0]);
        if (wait_cnt >= ack_delay) begin
          iDrawAck = 1'b1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          hs_count++;
          wait_cnt = 0;
        end else begin
          iDrawAck = 1'b0;
          wait_cnt++;
        end
      end else begin
        iDrawAck = (ack_delay == 0);
        wait_cnt = 0;
      end
    end
  end

  task automatic probe_all(input string tag, input int exp_zero);
    int zeros = 0;
    for (int i = 0; i < 32; i++) begin
      iProbeCell = 5'(i);
      #1;
      chk({tag, "_probe"}, oProbeNum, {1'b0, m_tbl[i]});
      if (oProbeNum == 0) zeros++;
    end
    chk({tag, "_zero_cells"}, zeros, exp_zero);
    @(negedge clk);
  endtask

  task automatic run_op(input string tag, input int op, input logic [4:0] lvl,
                        input int dly, input int poke, input int tiles);
    int exp_busy, busy;
    bit seen;
    exp_busy  = model_op(op, lvl, dly);
    ack_delay = dly;
    hs_count  = 0;
    iLevel    = lvl;
    iStart    = (op != 1);
    iClear    = (op != 0);
    @(negedge clk);
    iStart = 1'b0;
    iClear = 1'b0;
    busy = 0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (poke > 0 && cyc == poke) begin
        iStart = 1'b1;
        iClear = 1'b1;
        iLevel = 5'd20;
      end else begin
        iStart = 1'b0;
        iClear = 1'b0;
      end
      if (oDone) begin
        seen = 1'b1;
        break;
      end
      if (oBusy) busy++;
      @(negedge clk);
    end
    iStart = 1'b0;
    iClear = 1'b0;
    chk({tag, "_done_seen"}, seen, 1);
    chk({tag, "_busy_cycles"}, busy, exp_busy);
    chk({tag, "_handshakes"}, hs_count, tiles);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, oDone, 0);
    chk({tag, "_idle"}, {oBusy, oDrawReq}, 0);
    probe_all(tag, 32 - tiles);
  endtask

  typedef struct {
    int         op;
    logic [4:0] lvl;
    int         dly;
    int         poke;
    int         tiles;
  } vec_t;

  vec_t vecs [9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 5'd1,  0, 0,  1};
    vecs[1] = '{0, 5'd31, 0, 0,  31};
    vecs[2] = '{0, 5'd3,  5, 0,  3};
    vecs[3] = '{0, 5'd0,  0, 0,  1};
    vecs[4] = '{0, 5'd5,  0, 40, 5};
    vecs[5] = '{0, 5'd10, 0, 0,  10};
    vecs[6] = '{1, 5'd0,  0, 0,  0};
    vecs[7] = '{0, 5'd6,  1, 0,  6};
    vecs[8] = '{2, 5'd7,  0, 0,  0};

    iResetn    = 1'b0;
    iStart     = 1'b0;
    iClear     = 1'b0;
    iLevel     = '0;
    iProbeCell = '0;
    model_reset();
    #3;
    chk("reset_outputs", {oBusy, oDone, oDrawReq, oDrawCell, oDrawNum}, 0);
    chk("reset_state", dbg_state, ST_IDLE);
    probe_all("reset", 32);
    @(negedge clk);
    iResetn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].lvl, vecs[i].dly,
             vecs[i].poke, vecs[i].tiles);
    end

    // Reset during the draw of tile 4 of 10, then confirm the seed sequence repeats.
    iResetn = 1'b0;
    model_reset();
    @(negedge clk);
    iResetn = 1'b1;
    @(negedge clk);
    void'(model_op(0, 5'd10, 3));
    ack_delay = 3;
    hs_count  = 0;
    iLevel    = 5'd10;
    iStart    = 1'b1;
    @(negedge clk);
    iStart = 1'b0;
    begin
      bit found = 1'b0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
        if (oDrawReq && oDrawNum == 5'd4) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("rst_tile4_reached", found, 1);
    end
    #2;
    iResetn = 1'b0;
    #1;
    chk("rst_outputs_now", {oBusy, oDone, oDrawReq, oDrawCell, oDrawNum}, 0);
    chk("rst_state_now", dbg_state, ST_IDLE);
    chk("rst_handshakes", hs_count, 3);
    model_reset();
    probe_all("rst", 32);
    iResetn   = 1'b1;
    ack_delay = 0;
    @(negedge clk);
    run_op("after_rst", 0, 5'd10, 0, 0, 10);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
